mult_lane_dispatch: RTL and testbench
=====================================

// Module: mult_lane_dispatch
// PURPOSE
//  Parametrised AXI-stream dispatcher/collector placed in front of NL multiplier lanes.
//  Routes whole p and u packets round-robin to lanes and merges lane results back onto one z stream in dispatch order.
//  Uses a full valid/ready handshake, caps the number of jobs in flight, and flags malformed packet lengths.
//  Sits between the encoder input streams and an array of multiplier instances.
// PARAMETERS
//  N            16  coefficients per packet (p, u and z)
//  QW           64  p and z coefficient width
//  UW           1   u coefficient width
//  NL           2   number of lanes, >=2 (power of two not required)
//  MAX_INFLIGHT 4   max jobs dispatched but not yet fully returned, >=1
//  LW = $clog2(NL), IW = $clog2(MAX_INFLIGHT+1), CW = $clog2(N)  (derived localparams)
// PORTS
//  clk       in  1      clock
//  s_rst     in  1      synchronous reset, active high
//  p_data    in  QW     p coefficient
//  p_vld     in  1      p beat valid
//  p_last    in  1      last p beat of packet
//  p_rdy     out 1      p beat accepted when p_vld&p_rdy
//  u_data    in  UW     u coefficient
//  u_vld     in  1      u beat valid
//  u_last    in  1      last u beat of packet
//  u_rdy     out 1      u ready
//  z_data    out QW     result coefficient (registered)
//  z_vld     out 1      result valid
//  z_last    out 1      last result beat of packet
//  z_rdy     in  1      downstream ready
//  lp_data   out NL*QW  per-lane p data (p_data broadcast to every slice)
//  lp_vld    out NL     per-lane p valid
//  lp_last   out NL     per-lane p last
//  lp_rdy    in  NL     per-lane p ready
//  lu_data   out NL*UW  per-lane u data (broadcast); lu_vld/lu_last out NL, lu_rdy in NL
//  lz_data   in  NL*QW  per-lane result data
//  lz_vld    in  NL     per-lane result valid
//  lz_last   in  NL     per-lane result last
//  lz_rdy    out NL     per-lane result ready
//  inflight  out IW     current job count
//  len_err   out 1      sticky packet-length error
// BEHAVIOUR
//  Reset (s_rst=1 at a clk edge): clears p_sel, u_sel, z_sel, both beat counters, inflight, len_err and z_vld/z_last.
//   - z_data resets to 0.
//   - Reset mid-packet abandons all partial state; lanes are reset externally by the same s_rst.
//  Ingress, combinational, 0 latency:
//   - lp_vld[i] = p_vld & (i==p_sel) & go; lp_last[i] likewise; p_rdy = lp_rdy[p_sel] & go.
//   - go = 1 mid-packet (p_cnt!=0). At packet start (p_cnt==0), go = (inflight<MAX_INFLIGHT).
//   - The u path is identical using u_sel/u_cnt with no inflight gate; u is paired by lane order only.
//  Lane pointers:
//   - p_sel advances on an accepted p beat with p_last; u_sel and z_sel advance the same way on their own streams.
//   - Wrap NL-1 -> 0.
//  Length check (p and u independently):
//   - Counter increments per accepted beat and returns to 0 on the accepted last beat.
//   - len_err <= 1 if last arrives with cnt!=N-1, or cnt==N-1 is accepted without last.
//   - In the second case the counter wraps to 0 and the pointer does NOT advance.
//   - len_err stays set until reset.
//  Egress: one-stage output register, full throughput.
//   - lz_rdy[i] = (i==z_sel) & (!z_vld | z_rdy).
//   - An accepted lane beat loads z_* on the next edge.
//   - z_vld clears when z_rdy & z_vld and no new beat is loaded.
//   - Latency lane->z is 1 cycle; z holds stable while z_vld & !z_rdy.
//   - Lanes other than z_sel are never drained; results are delivered strictly in dispatch order.
//  inflight:
//   - +1 on accepted p last; -1 on z handshake with z_last.
//   - Both in the same cycle: unchanged. Never exceeds MAX_INFLIGHT, never underflows.
// TESTING
//  1. NL=2, N=16: 4 back-to-back p/u packets. Packets go to lanes 0,1,0,1; z returns packets 0..3 in order with z_last on beats 15,31,47,63.
//  2. MAX_INFLIGHT=2, z_rdy=0: p_rdy drops at the start of the 3rd packet with inflight=2. One z packet drained -> p_rdy rises the cycle after.
//  3. Random z_rdy backpressure (50%) over 8 packets: no beat lost or duplicated, z_data stable while stalled, scoreboard matches.
//  4. p packet with p_last on beat 9 (N=16): len_err=1 next cycle and stays 1. p_sel still advances; the next packet dispatches normally.
//  5. Assert s_rst mid-packet (beat 7, inflight=1): next cycle p_sel=u_sel=z_sel=0, inflight=0, z_vld=0, len_err=0.
//  6. NL=3: 6 packets -> lanes 0,1,2,0,1,2. Same-cycle p_last accept and z_last handshake leaves inflight unchanged.

Source files
------------

// File: rtl/mult_lane_dispatch_if.sv
// Stream bundle between the encoder, the dispatcher and its multiplier lanes.
// p/u/z are the merged streams; lp/lu/lz are the per-lane slices.
interface mult_lane_dispatch_if #(
    parameter int QW = 64,
    parameter int UW = 1,
    parameter int NL = 2
);
    logic [QW-1:0]    p_data;
    logic             p_vld;
    logic             p_last;
    logic             p_rdy;

    logic [UW-1:0]    u_data;
    logic             u_vld;
    logic             u_last;
    logic             u_rdy;

    logic [QW-1:0]    z_data;
    logic             z_vld;
    logic             z_last;
    logic             z_rdy;

    logic [NL*QW-1:0] lp_data;
    logic [NL-1:0]    lp_vld;
    logic [NL-1:0]    lp_last;
    logic [NL-1:0]    lp_rdy;

    logic [NL*UW-1:0] lu_data;
    logic [NL-1:0]    lu_vld;
    logic [NL-1:0]    lu_last;
    logic [NL-1:0]    lu_rdy;

    logic [NL*QW-1:0] lz_data;
    logic [NL-1:0]    lz_vld;
    logic [NL-1:0]    lz_last;
    logic [NL-1:0]    lz_rdy;

    modport slave (
        input  p_data, p_vld, p_last,
        output p_rdy,
        input  u_data, u_vld, u_last,
        output u_rdy,
        output z_data, z_vld, z_last,
        input  z_rdy,
        output lp_data, lp_vld, lp_last,
        input  lp_rdy,
        output lu_data, lu_vld, lu_last,
        input  lu_rdy,
        input  lz_data, lz_vld, lz_last,
        output lz_rdy
    );

    modport master (
        output p_data, p_vld, p_last,
        input  p_rdy,
        output u_data, u_vld, u_last,
        input  u_rdy,
        input  z_data, z_vld, z_last,
        output z_rdy,
        input  lp_data, lp_vld, lp_last,
        output lp_rdy,
        input  lu_data, lu_vld, lu_last,
        output lu_rdy,
        output lz_data, lz_vld, lz_last,
        input  lz_rdy
    );
endinterface

// File: rtl/mult_lane_dispatch.sv
// Round-robin packet dispatcher in front of NL multiplier lanes, with an
// in-order result collector, in-flight job cap and packet length checking.
module mult_lane_dispatch #(
    parameter int N            = 16,
    parameter int QW           = 64,
    parameter int UW           = 1,
    parameter int NL           = 2,
    parameter int MAX_INFLIGHT = 4,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 s_rst,
    mult_lane_dispatch_if.slave  bus,
    output logic [IW-1:0]        inflight,
    output logic                 len_err
);
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [LW-1:0] SEL_MAX = LW'(NL - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
    localparam logic [IW-1:0] INF_MAX = IW'(MAX_INFLIGHT);

    logic [LW-1:0] p_sel;
    logic [LW-1:0] u_sel;
    logic [LW-1:0] z_sel;
    logic [CW-1:0] p_cnt;
    logic [CW-1:0] u_cnt;

    logic [QW-1:0] z_data_q;
    logic          z_vld_q;
    logic          z_last_q;

    logic          p_go;
    logic          p_acc;
    logic          u_acc;
    logic          p_bad;
    logic          u_bad;
    logic          z_adv;
    logic          lz_acc;
    logic          job_in;
    logic          job_out;

    logic [QW-1:0] lz_sel_data;
    logic          lz_sel_last;
    logic          lz_sel_vld;

    // A new packet may only start while there is room for one more job.
    assign p_go = (p_cnt != '0) || (inflight < INF_MAX);

    assign bus.lp_data = {NL{bus.p_data}};
    assign bus.lu_data = {NL{bus.u_data}};

    assign z_adv = !z_vld_q || bus.z_rdy;

    always_comb begin
        bus.lp_vld  = '0;
        bus.lp_last = '0;
        bus.lu_vld  = '0;
        bus.lu_last = '0;
        bus.lz_rdy  = '0;
        bus.p_rdy   = 1'b0;
        bus.u_rdy   = 1'b0;
        lz_sel_data = '0;
        lz_sel_last = 1'b0;
        lz_sel_vld  = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (p_sel == LW'(i)) begin
                bus.lp_vld[i]  = bus.p_vld & p_go;
                bus.lp_last[i] = bus.p_last & p_go;
                bus.p_rdy      = bus.lp_rdy[i] & p_go;
            end
            if (u_sel == LW'(i)) begin
                bus.lu_vld[i]  = bus.u_vld;
                bus.lu_last[i] = bus.u_last;
                bus.u_rdy      = bus.lu_rdy[i];
            end
            if (z_sel == LW'(i)) begin
                bus.lz_rdy[i] = z_adv;
                lz_sel_data   = bus.lz_data[i*QW +: QW];
                lz_sel_last   = bus.lz_last[i];
                lz_sel_vld    = bus.lz_vld[i];
            end
        end
    end

    assign p_acc = bus.p_vld & bus.p_rdy;
    assign u_acc = bus.u_vld & bus.u_rdy;

    // Bad length: last on the wrong beat, or a full packet with no last.
    assign p_bad = p_acc & (bus.p_last != (p_cnt == CNT_MAX));
    assign u_bad = u_acc & (bus.u_last != (u_cnt == CNT_MAX));

    assign lz_acc  = lz_sel_vld & z_adv;
    assign job_in  = p_acc & bus.p_last;
    assign job_out = z_vld_q & bus.z_rdy & z_last_q;

    assign bus.z_data = z_data_q;
    assign bus.z_vld  = z_vld_q;
    assign bus.z_last = z_last_q;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            p_sel    <= '0;
            u_sel    <= '0;
            z_sel    <= '0;
            p_cnt    <= '0;
            u_cnt    <= '0;
            inflight <= '0;
            len_err  <= 1'b0;
            z_data_q <= '0;
            z_vld_q  <= 1'b0;
            z_last_q <= 1'b0;
        end else begin
            if (p_acc) begin
                if (bus.p_last || p_cnt == CNT_MAX) begin
                    p_cnt <= '0;
                end else begin
                    p_cnt <= p_cnt + 1'b1;
                end
                if (bus.p_last) begin
                    p_sel <= (p_sel == SEL_MAX) ? '0 : p_sel + 1'b1;
                end
            end

            if (u_acc) begin
                if (bus.u_last || u_cnt == CNT_MAX) begin
                    u_cnt <= '0;
                end else begin
                    u_cnt <= u_cnt + 1'b1;
                end
                if (bus.u_last) begin
                    u_sel <= (u_sel == SEL_MAX) ? '0 : u_sel + 1'b1;
                end
            end

            if (p_bad || u_bad) begin
                len_err <= 1'b1;
            end

            if (job_in && !job_out && inflight != INF_MAX) begin
                inflight <= inflight + 1'b1;
            end else if (job_out && !job_in && inflight != '0) begin
                inflight <= inflight - 1'b1;
            end

            // Output register: reload on a lane beat, otherwise drain.
            if (lz_acc) begin
                z_data_q <= lz_sel_data;
                z_vld_q  <= 1'b1;
                z_last_q <= lz_sel_last;
                if (lz_sel_last) begin
                    z_sel <= (z_sel == SEL_MAX) ? '0 : z_sel + 1'b1;
                end
            end else if (bus.z_rdy) begin
                z_vld_q  <= 1'b0;
                z_last_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_lane_dispatch.sv
// Bench for mult_lane_dispatch: modelled lanes, in-order z scoreboard,
// directed gating/length/reset steps plus a randomized backpressure run.
module tb_mult_lane_dispatch;
    localparam int N   = 16;
    localparam int QW  = 64;
    localparam int UW  = 1;
    localparam int NL  = 3;
    localparam int MI  = 2;
    localparam int IW  = $clog2(MI + 1);
    localparam int W   = QW + 1;
    localparam int LIM = 2000;

    logic          clk = 1'b0;
    logic          s_rst;
    logic [IW-1:0] inflight;
    logic          len_err;

    always #5 clk = ~clk;

    mult_lane_dispatch_if #(.QW(QW), .UW(UW), .NL(NL)) bus ();

    mult_lane_dispatch #(
        .N(N), .QW(QW), .UW(UW), .NL(NL), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk),
        .s_rst(s_rst),
        .bus(bus),
        .inflight(inflight),
        .len_err(len_err)
    );

    int checks = 0;
    int errors = 0;

    logic [QW:0] pq [NL][$];
    logic        uq [NL][$];
    logic [QW:0] expq [$];
    int          p_pkt, u_pkt, disp, ret;
    bit          zrand, zfix, lrnd, bubbles;
    logic        stall_q;
    logic [QW-1:0] held;

    function automatic logic [QW-1:0] lane_fn(input logic [QW-1:0] p,
                                              input logic u);
        return u ? ~p : p;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound(input string tag, input int w);
        checks++;
        assert (w < LIM) else begin
            errors++;
            $error("FAIL %s waited=%0d limit=%0d", tag, w, LIM);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    // Lane models and handshake-ready drivers, updated away from posedge.
    always @(negedge clk) begin
        bus.lp_rdy = lrnd ? NL'($urandom) : '1;
        bus.lu_rdy = lrnd ? NL'($urandom) : '1;
        bus.z_rdy  = zrand ? 1'($urandom) : zfix;
        for (int i = 0; i < NL; i++) begin
            if (pq[i].size() > 0 && uq[i].size() > 0) begin
                bus.lz_vld[i]          = 1'b1;
                bus.lz_last[i]         = pq[i][0][QW];
                bus.lz_data[i*QW +: QW] = lane_fn(pq[i][0][QW-1:0], uq[i][0]);
            end else begin
                bus.lz_vld[i]          = 1'b0;
                bus.lz_last[i]         = 1'b0;
                bus.lz_data[i*QW +: QW] = '0;
            end
        end
    end

    always @(posedge clk) begin
        if (s_rst) begin
            for (int i = 0; i < NL; i++) begin
                pq[i].delete();
                uq[i].delete();
            end
            expq.delete();
            p_pkt = 0; u_pkt = 0; disp = 0; ret = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) chk("z_hold", W'(bus.z_data), W'(held));
            stall_q = bus.z_vld & !bus.z_rdy;
            held    = bus.z_data;
            chk("inflight", W'(inflight), W'(disp - ret));
            for (int i = 0; i < NL; i++) begin
                if (bus.lp_vld[i] & bus.lp_rdy[i]) begin
                    chk("p_lane", W'(i), W'(p_pkt % NL));
                    pq[i].push_back({bus.p_last, bus.p_data});
                    if (bus.p_last) begin p_pkt++; disp++; end
                end
                if (bus.lu_vld[i] & bus.lu_rdy[i]) begin
                    chk("u_lane", W'(i), W'(u_pkt % NL));
                    uq[i].push_back(bus.u_data[0]);
                    if (bus.u_last) u_pkt++;
                end
                if (bus.lz_vld[i] & bus.lz_rdy[i]) begin
                    void'(pq[i].pop_front());
                    void'(uq[i].pop_front());
                end
            end
            if (bus.z_vld & bus.z_rdy) begin
                if (expq.size() > 0) begin
                    chk("z_beat", {bus.z_last, bus.z_data}, expq.pop_front());
                end else begin
                    chk("z_extra", W'(expq.size()), W'(1));
                end
                if (bus.z_last) ret++;
            end
        end
    end

    task automatic send_pkts(input int np, input int len);
        logic [QW-1:0] pd [$];
        logic          ud [$];
        for (int k = 0; k < np * len; k++) begin
            pd.push_back({$urandom, $urandom});
            ud.push_back(1'($urandom));
            expq.push_back({(k % len) == len - 1, lane_fn(pd[k], ud[k])});
        end
        fork
            begin
                for (int k = 0; k < np * len; k++) begin
                    int  w;
                    logic ok;
                    nstep();
                    if (bubbles && $urandom_range(3) == 0) begin
                        bus.p_vld = 1'b0;
                        nstep();
                    end
                    bus.p_vld  = 1'b1;
                    bus.p_data = pd[k];
                    bus.p_last = (k % len) == len - 1;
                    w = 0;
                    forever begin
                        ok = bus.p_rdy;
                        @(posedge clk);
                        if (ok || w >= LIM) break;
                        w++;
                        nstep();
                    end
                    bound("p_wait", w);
                end
                nstep();
                bus.p_vld  = 1'b0;
                bus.p_last = 1'b0;
            end
            begin
                for (int k = 0; k < np * len; k++) begin
                    int  w;
                    logic ok;
                    nstep();
                    if (bubbles && $urandom_range(3) == 0) begin
                        bus.u_vld = 1'b0;
                        nstep();
                    end
                    bus.u_vld  = 1'b1;
                    bus.u_data = ud[k];
                    bus.u_last = (k % len) == len - 1;
                    w = 0;
                    forever begin
                        ok = bus.u_rdy;
                        @(posedge clk);
                        if (ok || w >= LIM) break;
                        w++;
                        nstep();
                    end
                    bound("u_wait", w);
                end
                nstep();
                bus.u_vld  = 1'b0;
                bus.u_last = 1'b0;
            end
        join
    endtask

    task automatic drain();
        int w = 0;
        while ((expq.size() != 0 || disp != ret) && w < LIM) begin
            nstep();
            w++;
        end
        chk("drain_left", W'(expq.size()), W'(0));
        chk("drain_inflight", W'(inflight), W'(0));
    endtask

    initial begin
        int w;
        s_rst = 1'b1;
        zrand = 0; zfix = 0; lrnd = 0; bubbles = 0;
        bus.p_vld = 0; bus.p_last = 0; bus.p_data = '0;
        bus.u_vld = 0; bus.u_last = 0; bus.u_data = '0;
        bus.z_rdy = 0; bus.lp_rdy = '1; bus.lu_rdy = '1;
        bus.lz_vld = '0; bus.lz_last = '0; bus.lz_data = '0;
        repeat (2) @(posedge clk);
        nstep();
        s_rst = 1'b0;
        chk("rst_z_vld", W'(bus.z_vld), W'(0));
        chk("rst_z_last", W'(bus.z_last), W'(0));
        chk("rst_z_data", W'(bus.z_data), W'(0));
        chk("rst_inflight", W'(inflight), W'(0));
        chk("rst_len_err", W'(len_err), W'(0));
        chk("rst_p_rdy", W'(bus.p_rdy), W'(1));
        chk("rst_lp_vld", W'(bus.lp_vld), W'(0));

        // Back-to-back packets, free-flowing output.
        zfix = 1;
        send_pkts(4, N);
        drain();

        // Job cap: output stalled, third packet start must be held.
        zfix = 0;
        nstep();
        send_pkts(2, N);
        nstep();
        chk("cap_inflight", W'(inflight), W'(MI));
        bus.p_vld  = 1'b1;
        bus.p_last = 1'b0;
        bus.p_data = {$urandom, $urandom};
        #1;
        chk("cap_p_rdy", W'(bus.p_rdy), W'(0));
        chk("cap_lp_vld", W'(bus.lp_vld), W'(0));
        zfix = 1;
        w = 0;
        while (w < LIM) begin
            if (bus.z_vld & bus.z_rdy & bus.z_last) begin
                chk("cap_p_rdy_pre", W'(bus.p_rdy), W'(0));
                nstep();
                chk("cap_p_rdy_rise", W'(bus.p_rdy), W'(1));
                bus.p_vld = 1'b0;
                break;
            end
            nstep();
            w++;
        end
        bound("cap_release", w);
        send_pkts(1, N);
        drain();

        // Random backpressure on z and lane readies, random bubbles.
        zrand = 1; lrnd = 1; bubbles = 1;
        send_pkts(8, N);
        drain();
        zrand = 0; lrnd = 0; bubbles = 0; zfix = 1;
        nstep();

        // Short packet: error sticks, pointers keep advancing.
        chk("len_err_pre", W'(len_err), W'(0));
        send_pkts(1, 10);
        chk("len_err_set", W'(len_err), W'(1));
        send_pkts(2, N);
        drain();
        chk("len_err_sticky", W'(len_err), W'(1));

        // Reset in the middle of a packet with one job outstanding.
        zfix = 0;
        nstep();
        send_pkts(1, N);
        for (int j = 0; j < 8; j++) begin
            nstep();
            bus.p_vld  = 1'b1;
            bus.p_last = 1'b0;
            bus.p_data = {$urandom, $urandom};
            if (j == 7) chk("mid_p_rdy", W'(bus.p_rdy), W'(1));
            @(posedge clk);
        end
        nstep();
        bus.p_vld = 1'b0;
        chk("mid_inflight", W'(inflight), W'(1));
        chk("mid_p_sel", W'(dut.p_sel), W'(p_pkt % NL));
        chk("mid_z_sel", W'(dut.z_sel), W'(ret % NL));
        s_rst = 1'b1;
        @(posedge clk);
        nstep();
        s_rst = 1'b0;
        chk("post_p_sel", W'(dut.p_sel), W'(0));
        chk("post_u_sel", W'(dut.u_sel), W'(0));
        chk("post_z_sel", W'(dut.z_sel), W'(0));
        chk("post_inflight", W'(inflight), W'(0));
        chk("post_z_vld", W'(bus.z_vld), W'(0));
        chk("post_len_err", W'(len_err), W'(0));
        zfix = 1;
        send_pkts(2, N);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
